// File: rtl/ma_pkg.sv
// Shared constants, FSM state type and log2 helper for the moving-average band scheduler.
package ma_pkg;

  localparam int DEF_BIT_DEPTH = 16;
  localparam int DEF_CHANNELS  = 4;
  localparam int DEF_N         = 32;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_ACC,
    ST_OUT
  } state_t;

  // Ceiling log2; exact for the power-of-two averaging lengths.
  function automatic int log2c(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ma_band_sched_if.sv
// Sample-in / average-out handshake bundle of the band scheduler.
interface ma_band_sched_if
  import ma_pkg::*;
#(
  parameter int BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int CHANNELS  = DEF_CHANNELS
);

  localparam int CW = log2c(CHANNELS);

  logic [CHANNELS-1:0]           in_valid;
  logic [CHANNELS*BIT_DEPTH-1:0] in_data;
  logic [CHANNELS-1:0]           in_ready;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [BIT_DEPTH-1:0]   out_data;
  logic [CW-1:0]                 out_chan;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

endinterface

// File: rtl/ma_delay_ram.sv
// Single-port delay-line memory with registered read and no reset.
module ma_delay_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read data on a same-address write is never used, so the read/write order is irrelevant.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ma_band_sched.sv
// Time-shared per-channel moving average with round-robin input arbitration.
// Define MA_BAND_ROUND_EN for round-half-up output instead of truncation.
module ma_band_sched
  import ma_pkg::*;
#(
  parameter int BIT_DEPTH = DEF_BIT_DEPTH,
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int N         = DEF_N
) (
  input logic            clk,
  input logic            reset,
  ma_band_sched_if.slave bus
);

  localparam int LN    = log2c(N);
  localparam int CW    = log2c(CHANNELS);
  localparam int DEPTH = CHANNELS * N;
  localparam int AW    = log2c(DEPTH);
  localparam int ACC_W = BIT_DEPTH + LN;

  state_t                      r_state, w_state_next;
  logic [AW-1:0]               r_clr_addr;
  logic [CW-1:0]               r_chan;
  logic [CW-1:0]               r_rr;
  logic signed [BIT_DEPTH-1:0] r_sample;
  logic signed [ACC_W-1:0]     r_acc [CHANNELS];
  logic [LN-1:0]               r_ptr [CHANNELS];
  logic signed [BIT_DEPTH-1:0] r_out_data;
  logic [CW-1:0]               r_out_chan;

  logic [2*CHANNELS-1:0]       w_dbl;
  logic [CHANNELS-1:0]         w_rot;
  logic [CW:0]                 w_sum;
  logic                        w_found;
  logic [CW-1:0]               w_grant;
  logic [CW:0]                 w_rr_inc;
  logic [CW-1:0]               w_rr_next;
  logic signed [BIT_DEPTH-1:0] w_sample;
  logic [CHANNELS-1:0]         w_in_ready;

  logic                        w_ram_we;
  logic [AW-1:0]               w_ram_addr;
  logic [BIT_DEPTH-1:0]        w_ram_wdata;
  logic [BIT_DEPTH-1:0]        w_ram_rdata;

  logic signed [BIT_DEPTH:0]   w_diff;
  logic signed [ACC_W-1:0]     w_acc_new;
  logic signed [BIT_DEPTH-1:0] w_avg;

  // Rotate the request vector so bit 0 is the channel that has priority this round.
  assign w_dbl = {bus.in_valid, bus.in_valid};
  assign w_rot = w_dbl[r_rr +: CHANNELS];

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr} + (CW+1)'(k);
        if (w_sum >= (CW+1)'(CHANNELS)) w_sum = w_sum - (CW+1)'(CHANNELS);
        w_grant = w_sum[CW-1:0];
      end
    end
  end

  assign w_rr_inc  = {1'b0, w_grant} + (CW+1)'(1);
  assign w_rr_next = (w_rr_inc == (CW+1)'(CHANNELS)) ? '0 : w_rr_inc[CW-1:0];
  assign w_sample  = bus.in_data[int'(w_grant)*BIT_DEPTH +: BIT_DEPTH];

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = '0;
    w_ram_we     = 1'b0;
    w_ram_addr   = {r_chan, r_ptr[r_chan]};
    w_ram_wdata  = r_sample;
    case (r_state)
      ST_CLEAR: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_clr_addr;
        w_ram_wdata = '0;
        if (r_clr_addr == AW'(DEPTH - 1)) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_found) begin
          w_in_ready   = CHANNELS'(1) << w_grant;
          w_state_next = ST_READ;
        end
      end
      ST_READ:  w_state_next = ST_ACC;
      ST_ACC: begin
        w_ram_we     = 1'b1;
        w_state_next = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_CLEAR;
    endcase
  end

  ma_delay_ram #(
    .WIDTH (BIT_DEPTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Sum of the last N samples always fits ACC_W bits, so modular update is exact.
  assign w_diff    = BIT_DEPTH'(r_sample) - $signed(w_ram_rdata);
  assign w_acc_new = r_acc[r_chan] + ACC_W'(w_diff);

`ifdef MA_BAND_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_HALF = (ACC_W+1)'(1) << (LN - 1);
  logic signed [ACC_W:0] w_acc_rnd;
  assign w_acc_rnd = (ACC_W+1)'(w_acc_new) + ROUND_HALF;
  assign w_avg     = BIT_DEPTH'(w_acc_rnd >>> LN);
`else
  assign w_avg     = BIT_DEPTH'(w_acc_new >>> LN);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
      r_chan     <= '0;
      r_rr       <= '0;
      r_sample   <= '0;
      r_out_data <= '0;
      r_out_chan <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
        r_ptr[c] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR) r_clr_addr <= r_clr_addr + AW'(1);
      if (r_state == ST_IDLE && w_found) begin
        r_chan   <= w_grant;
        r_sample <= w_sample;
        r_rr     <= w_rr_next;
      end
      if (r_state == ST_ACC) begin
        r_acc[r_chan] <= w_acc_new;
        r_ptr[r_chan] <= r_ptr[r_chan] + LN'(1);
        r_out_data    <= w_avg;
        r_out_chan    <= r_chan;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_OUT);
  assign bus.out_data  = r_out_data;
  assign bus.out_chan  = r_out_chan;

endmodule

// File: tb/tb_ma_band_sched.sv
// Self-checking bench for ma_band_sched: table vectors, random traffic vs. a sum-of-history model.
module tb_ma_band_sched;
  import ma_pkg::*;

  localparam int BD = DEF_BIT_DEPTH;
  localparam int C  = DEF_CHANNELS;
  localparam int N  = DEF_N;
`ifdef MA_BAND_ROUND_EN
  localparam int HALF = N / 2;
`else
  localparam int HALF = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ma_band_sched_if #(.BIT_DEPTH(BD), .CHANNELS(C)) bus ();

  ma_band_sched #(.BIT_DEPTH(BD), .CHANNELS(C), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: last N samples per channel and the round-robin start point.
  int hist [C][N];
  int hptr [C];
  int rr_next;

  typedef struct {
    int chan;
    int sample;
    int exp_out;
  } vec_t;
  vec_t vecs [40];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      hptr[c] = 0;
      for (int i = 0; i < N; i++) hist[c][i] = 0;
    end
    rr_next = 0;
  endtask

  function automatic int floor_div(input longint s, input int d);
    longint q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return int'(q);
  endfunction

  task automatic model_push(input int ch, input int sample, output int avg);
    longint s;
    hist[ch][hptr[ch]] = sample;
    hptr[ch] = (hptr[ch] + 1) % N;
    s = HALF;
    for (int i = 0; i < N; i++) s += hist[ch][i];
    avg = floor_div(s, N);
  endtask

  function automatic int model_grant(input logic [C-1:0] m);
    for (int k = 0; k < C; k++) begin
      if (m[(rr_next + k) % C]) return (rr_next + k) % C;
    end
    return -1;
  endfunction

  task automatic set_chan_data(input int ch, input int v);
    bus.in_data[ch*BD +: BD] = BD'(v);
  endtask

  task automatic set_rand_data();
    for (int c = 0; c < C; c++) set_chan_data(c, int'($signed(BD'($urandom))));
  endtask

  // One full transaction; caller is just past a falling edge with in_data already driven.
  task automatic do_txn(input logic [C-1:0] mask, input int stall, input int exp_wait, output int got);
    int waited, lat, exp_g, g, samp, exp_out;
    bit busy_ready, early_out;
    got = 0;
    bus.in_valid  = mask;
    bus.out_ready = (stall == 0);
    waited = 0;
    early_out = 0;
    #1;
    while (bus.in_ready == '0 && waited < 2000) begin
      if (bus.out_valid) early_out = 1;
      @(negedge clk); #1;
      waited++;
    end
    check("no_out_while_waiting", early_out, 0);
    if (bus.in_ready == '0) begin
      checks++; failures++;
      $display("FAIL grant_timeout: got no in_ready after %0d cycles required a grant", waited);
      bus.out_ready = 1'b1;
      return;
    end
    if (exp_wait >= 0) check("clear_cycles", waited, exp_wait);
    check("in_ready_onehot", $onehot(bus.in_ready), 1);
    exp_g = model_grant(mask);
    g = 0;
    for (int i = 0; i < C; i++) if (bus.in_ready[i]) g = i;
    check("grant_chan", g, exp_g);
    samp = int'($signed(bus.in_data[exp_g*BD +: BD]));
    model_push(exp_g, samp, exp_out);
    rr_next = (exp_g + 1) % C;
    lat = 0;
    busy_ready = 0;
    do begin
      @(negedge clk); #1;
      lat++;
      if (!bus.out_valid && bus.in_ready != '0) busy_ready = 1;
    end while (!bus.out_valid && lat < 10);
    check("latency", lat, 3);
    if (!bus.out_valid) begin
      bus.out_ready = 1'b1;
      return;
    end
    check("in_ready_busy", busy_ready, 0);
    check("out_chan", bus.out_chan, exp_g);
    check("out_data", $signed(bus.out_data), exp_out);
    got = int'($signed(bus.out_data));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", $signed(bus.out_data), exp_out);
      check("stall_chan", bus.out_chan, exp_g);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    check("out_released", bus.out_valid, 0);
    $display("txn ch=%0d in=%0d out=%0d exp=%0d lat=%0d stall=%0d", g, samp, got, exp_out, lat, stall);
  endtask

  initial begin
    int got, waited, k;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      k = (i + 1 <= N) ? i + 1 : N;
      vecs[i].chan    = 0;
      vecs[i].sample  = 1000;
      vecs[i].exp_out = (k * 1000 + HALF) / N;
    end

    reset         = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", $signed(bus.out_data), 0);
    check("rst_out_chan", bus.out_chan, 0);
    @(negedge clk);

    // Ch0 constant ramp-up then steady; the first entry also measures the clear sweep.
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      set_chan_data(vecs[i].chan, vecs[i].sample);
      do_txn(C'(1) << vecs[i].chan, 0, (i == 0) ? C*N : -1, got);
      check("table_out", got, vecs[i].exp_out);
    end

    // Fresh reset, all channels requesting: grants must rotate from channel 0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      set_rand_data();
      do_txn('1, 0, (i == 0) ? C*N : -1, got);
    end

    // Random request masks with random output back-pressure.
    for (int i = 0; i < 60; i++) begin
      set_rand_data();
      do_txn(C'($urandom_range(1, (1 << C) - 1)), int'($urandom_range(0, 3)), -1, got);
    end

    // Ten-cycle stall in OUT with every other channel requesting.
    set_rand_data();
    do_txn('1, 10, -1, got);

    // Full-scale negative input on ch2 must settle exactly at the minimum.
    set_chan_data(2, -32768);
    for (int i = 0; i < 64; i++) do_txn(C'(4), 0, -1, got);
    check("ch2_min_settle", got, -32768);

    // Reset during ACC: aborted sample leaves no trace, sweep restarts.
    set_chan_data(0, 1000);
    bus.in_valid = C'(1);
    waited = 0;
    #1;
    while (bus.in_ready == '0 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check("abort_grant", bus.in_ready, 1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("abort_acc_no_out", bus.out_valid, 0);
    reset = 1'b1;
    #1;
    check("abort_rst_out_valid", bus.out_valid, 0);
    check("abort_rst_out_data", $signed(bus.out_data), 0);
    check("abort_rst_in_ready", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_txn(C'(1), 0, C*N, got);
    check("abort_first_out", got, (1000 + HALF) / N);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ma_band_sched.md
MA_BAND_SCHED -- requirements
Module: ma_band_sched

Interface
REQ-001 Parameter BIT_DEPTH, default 16, sample width, signed two's complement.
REQ-002 Parameter CHANNELS, default 4, number of vocoder bands sharing the engine, 2..16.
REQ-003 Parameter N, default 32, moving-average length per channel, power of two, 2..256.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  CHANNELS  per-channel sample offered.
REQ-007 in_data  input  CHANNELS*BIT_DEPTH  per-channel sample; channel c occupies bits [c*BIT_DEPTH +: BIT_DEPTH].
REQ-008 in_ready  output  CHANNELS  per-channel accept; one-hot or zero.
REQ-009 out_valid  output  1  averaged result available.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 out_data  output  BIT_DEPTH  signed moving average of the granted channel.
REQ-012 out_chan  output  clog2(CHANNELS)  channel index of out_data.

Function
REQ-013 A single subtract/accumulate datapath and one delay memory of CHANNELS*N words, addressed {chan, ptr[chan]}, SHALL be time-shared by all channels.
REQ-014 FSM states: CLEAR, IDLE, READ, ACC, OUT; CLEAR is entered on reset.
REQ-015 CLEAR: write zero to every memory address, one per cycle, CHANNELS*N cycles, in_ready = 0; then IDLE.
REQ-016 IDLE: round-robin grant, starting after the last served channel, over channels with in_valid high; in_ready[g] = 1 for that cycle only; the handshake latches chan and sample; go to READ.
REQ-017 IDLE with no in_valid: stay, hold the round-robin pointer.
REQ-018 READ: issue a synchronous read of the oldest sample at {chan, ptr[chan]}; go to ACC.
REQ-019 ACC: diff = new - old at BIT_DEPTH+1 bits; acc[chan] += sign-extended diff at BIT_DEPTH+log2(N) bits; write the new sample to the same address; ptr[chan] increments, wrapping N-1 to 0; go to OUT.
REQ-020 OUT: out_valid = 1, out_data = acc[chan] >>> log2(N) (arithmetic), out_chan = chan; all stable until out_ready; on the handshake go to IDLE.
REQ-021 Latency: in handshake at cycle T -> out_valid first high at T+3; throughput at most one sample per 4 cycles.
REQ-022 For the first N samples of a channel, the average includes the zeroed history (ramp-up), not a partial mean.
REQ-023 The accumulator SHALL never overflow: |acc| <= N*2^(BIT_DEPTH-1).
REQ-024 Other channels' in_valid during a transaction SHALL be ignored; their in_ready stays low.

Reset
REQ-025 Reset asserted: state = CLEAR, clear address = 0, in_ready = 0, out_valid = 0, out_data = 0, out_chan = 0, all acc = 0, all ptr = 0, round-robin pointer = 0.
REQ-026 Reset mid-transaction aborts it with no output produced and restarts the full CLEAR sweep.

Configuration
REQ-027 Macro MA_BAND_ROUND_EN defined: out_data = (acc[chan] + 2^(log2(N)-1)) >>> log2(N), round half up, with one guard bit so the addition cannot wrap.
REQ-028 Macro MA_BAND_ROUND_EN undefined: plain truncating arithmetic shift as in REQ-020.

Structure
REQ-029 Shared package ma_pkg SHALL hold the default BIT_DEPTH/CHANNELS/N constants, the FSM state enum type and the log2 helper function.
REQ-030 The delay memory SHALL be a sub-module ma_delay_ram: single port, synchronous read, write-first not relied on, no reset.

Verification
REQ-031 Reset, then hold in_valid = 0 -> in_ready = 0 for exactly CHANNELS*N (128) cycles, then IDLE.
REQ-032 Ch0 constant 1000, 32 samples, out_ready = 1 -> outputs 31, 62, ... (k*1000>>5), 32nd output = 1000, then steady at 1000; latency 3.
REQ-033 All four channels valid continuously -> grants ordered 0,1,2,3,0,...; out_chan matches; per-channel averages independent.
REQ-034 out_ready held low 10 cycles in OUT -> out_valid, out_data and out_chan stable; no in_ready asserted.
REQ-035 Ch2 constant -32768 for 64 samples -> out_data settles to exactly -32768, with no overflow.
REQ-036 Reset pulsed during ACC -> no output, CLEAR sweep repeats, next ch0 sample 1000 -> out_data 31.
